// File: rtl/acc_share_sched.sv
// acc_share_sched: one W-bit adder shared round-robin among NREQ requesters,
// each owning a private accumulator. Commands are ADD, ACC, CLR and READ.
// One command is in flight at a time. It is granted in IDLE, computed in
// EXEC, and held on the response channel in RESP until the consumer accepts.
// rst_n is assumed to be released synchronously by an upstream synchroniser.

module acc_share_sched #(
    parameter int NREQ = 4,
    parameter int W    = 32,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [2*NREQ-1:0]   req_op,
    input  logic [W*NREQ-1:0]   req_a,
    input  logic [W*NREQ-1:0]   req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [W-1:0]        rsp_data,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_ACC  = 2'b01,
        OP_CLR  = 2'b10,
        OP_READ = 2'b11
    } op_t;

    // Requester index base+off, wrapped at NREQ rather than at 2**IDW.
    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        return IDW'(sum % NREQ);
    endfunction

    state_t             state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [W-1:0]       acc_q [NREQ];
    logic [W-1:0]       acc_d [NREQ];
    op_t                op_q, op_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [IDW-1:0]     id_q, id_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic [W-1:0]       rsp_data_q, rsp_data_d;
    logic               busy_q;

    logic               grant_found_s;
    logic [IDW-1:0]     grant_id_s;
    logic               handshake_s;
    logic [1:0]         sel_op_s;
    logic [W-1:0]       sel_a_s;
    logic [W-1:0]       sel_b_s;
    logic [W-1:0]       acc_sel_s;
    logic [W-1:0]       add_x_s;
    logic [W-1:0]       sum_s;

    // Round-robin search: first valid requester at or after rr_ptr_q.
    always_comb begin
        grant_found_s = 1'b0;
        grant_id_s    = {IDW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found_s && req_valid[rr_idx(rr_ptr_q, k)]) begin
                grant_found_s = 1'b1;
                grant_id_s    = rr_idx(rr_ptr_q, k);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Grant is offered only in IDLE and only to the winner; mux its command.
    always_comb begin
        req_ready = {NREQ{1'b0}};
        sel_op_s  = 2'b00;
        sel_a_s   = {W{1'b0}};
        sel_b_s   = {W{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id_s == IDW'(i)) begin
                req_ready[i] = (state_q == ST_IDLE) && grant_found_s;
                sel_op_s     = req_op[2*i +: 2];
                sel_a_s      = req_a[W*i +: W];
                sel_b_s      = req_b[W*i +: W];
            end else begin
                req_ready[i] = 1'b0;
            end
        end
    end

    assign handshake_s = (state_q == ST_IDLE) && grant_found_s;

    // Next-state logic plus command capture and pointer advance on grant.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        id_d     = id_q;
        case (state_q)
            ST_IDLE: begin
                if (handshake_s) begin
                    state_d  = ST_EXEC;
                    rr_ptr_d = rr_idx(grant_id_s, 1);
                    op_d     = op_t'(sel_op_s);
                    a_d      = sel_a_s;
                    b_d      = sel_b_s;
                    id_d     = grant_id_s;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Shared adder: ADD sums a+b, every other op offers acc[id]+a.
    always_comb begin
        acc_sel_s = acc_q[id_q];
        if (op_q == OP_ADD) begin
            add_x_s = b_q;
        end else begin
            add_x_s = acc_sel_s;
        end
        sum_s = add_x_s + a_q;
    end

    // Accumulator update and response formation in EXEC; release on accept.
    always_comb begin
        acc_d       = acc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (state_q == ST_EXEC) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q;
            case (op_q)
                OP_ADD: begin
                    rsp_data_d = sum_s;
                end
                OP_ACC: begin
                    acc_d[id_q] = sum_s;
                    rsp_data_d  = sum_s;
                end
                OP_CLR: begin
                    acc_d[id_q] = {W{1'b0}};
                    rsp_data_d  = acc_sel_s;
                end
                OP_READ: begin
                    rsp_data_d = acc_sel_s;
                end
                default: begin
                    rsp_data_d = rsp_data_q;
                end
            endcase
        end else if ((state_q == ST_RESP) && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // Control, command and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= {IDW{1'b0}};
            op_q        <= OP_ADD;
            a_q         <= {W{1'b0}};
            b_q         <= {W{1'b0}};
            id_q        <= {IDW{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= {IDW{1'b0}};
            rsp_data_q  <= {W{1'b0}};
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    // Per-requester accumulators, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                acc_q[i] <= {W{1'b0}};
            end
        end else begin
            acc_q <= acc_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_acc_share_sched.sv
// Bench for acc_share_sched: a transaction-level model (arbitration by a
// modular search, accumulators as a plain array) is checked every cycle,
// plus directed scenarios with literal expected values.

module tb_acc_share_sched;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [2*NREQ-1:0]   req_op = '0;
    logic [W*NREQ-1:0]   req_a = '0;
    logic [W*NREQ-1:0]   req_b = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [IDW-1:0]      rsp_id;
    logic [W-1:0]        rsp_data;
    logic                busy;

    acc_share_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } cmd_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   data;
    } rsp_t;

    cmd_t            cq [NREQ][$];
    rsp_t            rsp_log[$];
    int              grant_log[$];
    logic [NREQ-1:0] hs_mask = '0;
    int              cyc = 0;
    int              last_grant_cyc = 0;
    int              last_rsp_cyc = 0;
    logic            prev_rsp_valid = 1'b0;
    bit              drop_en = 1'b0;
    bit              rdy_rand = 1'b0;
    logic            rdy_fixed = 1'b1;
    int              n_chk = 0;
    int              n_fail = 0;

    // Reference model state
    logic [W-1:0]    m_acc [NREQ];
    int              m_rr;
    int              m_phase;     // 0 waiting for grant, 1 computing, 2 presenting
    int              m_id;
    cmd_t            m_cmd;
    logic            m_rsp_valid;
    logic [IDW-1:0]  m_rsp_id;
    logic [W-1:0]    m_rsp_data;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Per-cycle model: compare outputs, log handshakes, then advance one clock.
    always @(negedge clk) begin : mon
        logic [NREQ-1:0] exp_rdy;
        int              win;
        rsp_t            r;
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) m_acc[i] = '0;
            m_rr = 0; m_phase = 0; m_id = 0; m_cmd = '0;
            m_rsp_valid = 1'b0; m_rsp_id = '0; m_rsp_data = '0;
            hs_mask = '0;
            prev_rsp_valid = 1'b0;
            chk("rst_req_ready", req_ready, '0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_busy", busy, 0);
        end else begin
            exp_rdy = '0;
            win = -1;
            if (m_phase == 0) begin
                for (int k = 0; k < NREQ; k++)
                    if (win < 0 && req_valid[(m_rr + k) % NREQ]) win = (m_rr + k) % NREQ;
            end
            if (win >= 0) exp_rdy[win] = 1'b1;
            chk("req_ready", req_ready, exp_rdy);
            chk("rsp_valid", rsp_valid, m_rsp_valid);
            chk("rsp_id", rsp_id, m_rsp_id);
            chk("rsp_data", rsp_data, m_rsp_data);
            chk("busy", busy, m_phase != 0);

            hs_mask = req_valid & req_ready;
            for (int i = 0; i < NREQ; i++)
                if (hs_mask[i]) begin
                    grant_log.push_back(i);
                    last_grant_cyc = cyc;
                end
            if (rsp_valid && !prev_rsp_valid) last_rsp_cyc = cyc;
            prev_rsp_valid = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                r.id = rsp_id;
                r.data = rsp_data;
                rsp_log.push_back(r);
            end

            if (m_phase == 0) begin
                if (win >= 0) begin
                    m_id = win;
                    m_cmd.op = req_op[2*win +: 2];
                    m_cmd.a  = req_a[W*win +: W];
                    m_cmd.b  = req_b[W*win +: W];
                    m_rr = (win + 1) % NREQ;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                case (m_cmd.op)
                    2'b00: m_rsp_data = m_cmd.a + m_cmd.b;
                    2'b01: begin m_acc[m_id] = m_acc[m_id] + m_cmd.a; m_rsp_data = m_acc[m_id]; end
                    2'b10: begin m_rsp_data = m_acc[m_id]; m_acc[m_id] = '0; end
                    default: m_rsp_data = m_acc[m_id];
                endcase
                m_rsp_id = m_id[IDW-1:0];
                m_rsp_valid = 1'b1;
                m_phase = 2;
            end else begin
                if (rsp_ready) begin
                    m_rsp_valid = 1'b0;
                    m_phase = 0;
                end
            end
        end
    end

    // Requester driver: present queued commands, drop on grant, optionally withdraw.
    always @(posedge clk) begin
        #1;
        rsp_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;
        if (!rst_n) begin
            req_valid = '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (hs_mask[i]) begin
                    void'(cq[i].pop_front());
                    req_valid[i] = 1'b0;
                end else if (req_valid[i] && drop_en && $urandom_range(0, 5) == 0) begin
                    req_valid[i] = 1'b0;
                    continue;
                end
                if (!req_valid[i] && cq[i].size() > 0) begin
                    req_valid[i]       = 1'b1;
                    req_op[2*i +: 2]   = cq[i][0].op;
                    req_a[W*i +: W]    = cq[i][0].a;
                    req_b[W*i +: W]    = cq[i][0].b;
                end
            end
        end
    end

    task automatic push_cmd(input int id, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        cmd_t c;
        c.op = op; c.a = a; c.b = b;
        cq[id].push_back(c);
    endtask

    task automatic wait_rsp(input int n, input string nm);
        int t;
        t = 0;
        while (rsp_log.size() < n && t < 300) begin
            @(negedge clk); #1;
            t++;
        end
        if (rsp_log.size() < n) begin
            n_chk++; n_fail++;
            $display("FAIL %s_timeout: got %0d responses, expected %0d", nm, rsp_log.size(), n);
        end
    endtask

    task automatic run_cmd(input int id, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] exp_d, input string nm);
        rsp_log.delete();
        push_cmd(id, op, a, b);
        wait_rsp(1, nm);
        if (rsp_log.size() > 0) begin
            chk({nm, "_id"}, rsp_log[0].id, id);
            chk({nm, "_data"}, rsp_log[0].data, exp_d);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        grant_log.delete();
        rsp_log.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[5];
        int t;
        cmd_t c;
        int r;

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk); #1;
        chk("init_busy", busy, 0);
        chk("init_rsp_valid", rsp_valid, 0);
        chk("init_req_ready", req_ready, 0);

        // ADD on requester 2, latency, accumulator untouched
        run_cmd(2, 2'b00, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, "t1_add");
        chk("t1_latency", last_rsp_cyc - last_grant_cyc, 2);
        run_cmd(2, 2'b11, 32'h0, 32'h0, 32'h0000_0000, "t1_acc2");

        // ACC wraparound on requester 1
        run_cmd(1, 2'b01, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, "t2_acc1");
        run_cmd(1, 2'b01, 32'h0000_0002, 32'h0, 32'h0000_0001, "t2_acc2");
        run_cmd(1, 2'b11, 32'h0, 32'h0, 32'h0000_0001, "t2_read");

        // Read-and-clear on requester 0
        run_cmd(0, 2'b01, 32'h0000_0010, 32'h0, 32'h0000_0010, "t3_acc");
        run_cmd(0, 2'b10, 32'h0, 32'h0, 32'h0000_0010, "t3_clr");
        run_cmd(0, 2'b11, 32'h0, 32'h0, 32'h0000_0000, "t3_read");

        // Randomised traffic with backpressure and withdrawn requests
        grant_log.delete();
        rsp_log.delete();
        rdy_rand = 1'b1;
        drop_en = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk); #1;
            if ($urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, NREQ - 1);
                if (cq[r].size() < 3) begin
                    c.op = 2'($urandom_range(0, 3));
                    c.a  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 15))) : $urandom();
                    c.b  = $urandom();
                    cq[r].push_back(c);
                end
            end
        end
        drop_en = 1'b0;
        rdy_rand = 1'b0;
        rdy_fixed = 1'b1;
        t = 0;
        while ((cq[0].size() + cq[1].size() + cq[2].size() + cq[3].size() != 0 || busy) && t < 500) begin
            @(negedge clk); #1;
            t++;
        end
        chk("rand_drained", t < 500, 1);
        repeat (3) @(negedge clk);
        #1;
        chk("rand_rsp_per_grant", rsp_log.size(), grant_log.size());

        // Fairness: all four requesting from reset
        do_reset();
        push_cmd(0, 2'b00, 32'h100, 32'h1);
        push_cmd(1, 2'b00, 32'h110, 32'h1);
        push_cmd(2, 2'b00, 32'h120, 32'h1);
        push_cmd(3, 2'b00, 32'h130, 32'h1);
        push_cmd(0, 2'b00, 32'h200, 32'h2);
        wait_rsp(5, "t4");
        exp_order = '{0, 1, 2, 3, 0};
        if (rsp_log.size() >= 5 && grant_log.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("t4_grant%0d", i), grant_log[i], exp_order[i]);
                chk($sformatf("t4_rspid%0d", i), rsp_log[i].id, exp_order[i]);
            end
            chk("t4_data0", rsp_log[0].data, 32'h101);
            chk("t4_data4", rsp_log[4].data, 32'h202);
        end

        // Backpressure: response held, no grants, then round-robin resumes
        do_reset();
        rdy_fixed = 1'b0;
        push_cmd(1, 2'b00, 32'h11, 32'h22);
        push_cmd(3, 2'b00, 32'h30, 32'h3);
        t = 0;
        while (!rsp_valid && t < 50) begin
            @(negedge clk); #1;
            t++;
        end
        chk("t5_rsp_seen", rsp_valid, 1);
        push_cmd(0, 2'b00, 32'h1, 32'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("t5_hold_valid", rsp_valid, 1);
            chk("t5_hold_id", rsp_id, 1);
            chk("t5_hold_data", rsp_data, 32'h33);
            chk("t5_hold_busy", busy, 1);
            chk("t5_hold_ready", req_ready, 0);
        end
        rdy_fixed = 1'b1;
        wait_rsp(3, "t5");
        if (grant_log.size() >= 3 && rsp_log.size() >= 3) begin
            chk("t5_grant0", grant_log[0], 1);
            chk("t5_grant1", grant_log[1], 3);
            chk("t5_grant2", grant_log[2], 0);
            chk("t5_data1", rsp_log[1].data, 32'h33);
            chk("t5_data2", rsp_log[2].data, 32'h2);
        end

        // Reset during EXEC of ACC on requester 3
        do_reset();
        push_cmd(3, 2'b01, 32'h7, 32'h0);
        t = 0;
        while (grant_log.size() == 0 && t < 50) begin
            @(negedge clk); #1;
            t++;
        end
        chk("t6_granted", grant_log.size(), 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_busy", busy, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        run_cmd(3, 2'b11, 32'h0, 32'h0, 32'h0000_0000, "t6_read");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/acc_share_sched.md
Name: acc_share_sched

Overview:
Round-robin scheduler that shares one W-bit adder among NREQ requesters. Each requester owns a private accumulator register inside the block. A requester issues ADD, ACC, CLR or READ commands over a valid/ready handshake. The block serialises the commands through the single adder and returns each result, tagged with the requester ID, on one response channel with backpressure.

Parameters:
NREQ, 4, number of requesters (2..16)
W, 32, operand/accumulator/result width
IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester command valid
req_ready  output  NREQ  per-requester command accept (combinational)
req_op  input  2*NREQ  op of requester i in bits [2i+1:2i]: 00 ADD, 01 ACC, 10 CLR, 11 READ
req_a  input  W*NREQ  operand A of requester i in bits [W*i+W-1:W*i]
req_b  input  W*NREQ  operand B of requester i (used by ADD only)
rsp_valid  output  1  response valid
rsp_ready  input  1  response accept
rsp_id  output  IDW  requester ID of the response
rsp_data  output  W  response data
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, rr_ptr = 0, all accumulators = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0, busy = 0, req_ready = 0.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE: arbitration.
  - Round-robin search starts at rr_ptr over req_valid and picks the first set bit (index rr_ptr, rr_ptr+1, ... mod NREQ).
  - req_ready[winner] = 1 in the same cycle; every other req_ready bit = 0.
  - req_ready is 0 in every bit when no request is valid, and in EXEC and RESP.
  - On handshake (valid & ready):
    - Latch op, a, b and winner ID into internal registers.
    - rr_ptr <= (winner+1) mod NREQ.
    - Go to EXEC.
  - With no request pending, stay in IDLE; rr_ptr is unchanged.
- EXEC: one cycle; the shared adder is used here only.
  - ADD: rsp_data <= a + b; accumulator unchanged.
  - ACC: acc[id] <= acc[id] + a; rsp_data <= the new accumulator value.
  - CLR: acc[id] <= 0; rsp_data <= the old accumulator value (read-and-clear).
  - READ: rsp_data <= acc[id]; accumulator unchanged.
  - rsp_id <= id; rsp_valid <= 1; go to RESP.
- RESP: rsp_valid = 1 and rsp_id/rsp_data are held stable until rsp_ready = 1.
  - On handshake: rsp_valid <= 0, return to IDLE.
  - rsp_data/rsp_id keep their last value after handshake.
- Latency and throughput:
  - Request handshake in cycle T gives rsp_valid = 1 in cycle T+2.
  - With rsp_ready held at 1, the maximum rate is one command per 3 cycles.
- Arithmetic: all sums are modulo 2**W; carry-out is discarded; no overflow flag.
- Requester rules: a requester holds req_valid, op and operands stable until its req_ready. Dropping req_valid before grant is allowed and loses nothing.
- Other requesters stay pending through EXEC and RESP. Exactly one command is ever in flight.
- Simultaneous requests: exactly one is granted per IDLE cycle, in strict round-robin order. No starvation: every waiting requester is served within NREQ commands.
- req_valid bits at index >= NREQ do not exist; rr_ptr wraps at NREQ, not at 2**IDW.
- Reset asserted mid-operation: the in-flight command is dropped, no response is issued, and all accumulators return to 0.

Test Plan:
1. ADD single requester: req 2 sends ADD a=0x0000_0005 b=0x0000_0003 at T -> req_ready[2]=1 at T; rsp_valid at T+2 with rsp_id=2, rsp_data=0x0000_0008; acc[2] stays 0.
2. ACC wrap: requester 1 sends ACC a=0xFFFF_FFFF, then ACC a=0x0000_0002, then READ -> responses 0xFFFF_FFFF, 0x0000_0001, 0x0000_0001.
3. Read-and-clear: after acc[0]=0x10, requester 0 sends CLR then READ -> responses 0x10, then 0x0.
4. Fairness: all four req_valid held high with ADD after reset -> grant order 0,1,2,3,0; each response's rsp_id matches the grant order; rr_ptr wraps correctly.
5. Backpressure: rsp_ready=0 for 5 cycles while rsp_valid=1 -> rsp_data/rsp_id stable, busy=1, all req_ready=0. On rsp_ready=1, return to IDLE and the next grant goes to the following round-robin index.
6. Reset mid-op: assert rst_n=0 during EXEC of ACC a=7 on requester 3 -> rsp_valid=0 immediately. After release, a READ from requester 3 returns 0.
